// File: rtl/vpu_win_gen.sv
// vpu_win_gen: frame-synchronous window hit generator.
// Shadows per-channel window config at vsync rise, tracks video timing
// (vsync/de) and emits the winning channel and window-relative coords per pixel.
module vpu_win_gen #(
    parameter logic [15:0] WIN_H    = 16'd1080,
    parameter int          HBASE_SH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vsync_i,
    input  logic        de_i,
    input  logic [7:0]  base_ch0_hsync,
    input  logic [7:0]  base_ch1_hsync,
    input  logic [7:0]  base_ch2_hsync,
    input  logic [15:0] base_ch0_vsync,
    input  logic [15:0] base_ch1_vsync,
    input  logic [15:0] base_ch2_vsync,
    input  logic [15:0] width_ch0,
    input  logic [15:0] width_ch1,
    input  logic [15:0] width_ch2,
    input  logic [7:0]  chx_load_en,
    input  logic [7:0]  img_mode,
    output logic        out_de,
    output logic [2:0]  win_hit,
    output logic [1:0]  win_sel,
    output logic [15:0] win_x,
    output logic [15:0] win_y,
    output logic        frame_start,
    output logic [7:0]  img_mode_act
);

    typedef enum logic [1:0] {SYNC_WAIT, BLANK, LINE} state_t;

    state_t      r_state;
    logic        r_vs_d;
    logic [15:0] r_xcnt;
    logic [15:0] r_ycnt;
    logic [7:0]  r_bh [3];
    logic [15:0] r_bv [3];
    logic [15:0] r_w  [3];

    logic        w_vs_rise;
    logic        w_acc;
    logic [7:0]  w_in_bh [3];
    logic [15:0] w_in_bv [3];
    logic [15:0] w_in_w  [3];
    logic [16:0] w_xs    [3];
    logic [2:0]  w_hit;
    logic [1:0]  w_sel;
    logic [15:0] w_wx;
    logic [15:0] w_wy;
    logic [4:0]  w_unused_load_en;

    assign w_unused_load_en = chx_load_en[7:3];
    assign w_vs_rise        = vsync_i & ~r_vs_d;
    // A pixel counts only once timing is locked and never in the frame-start cycle
    assign w_acc            = de_i & (r_state != SYNC_WAIT) & ~w_vs_rise;

    // Gather per-channel config inputs into arrays for uniform handling
    always_comb begin
        w_in_bh[0] = base_ch0_hsync; w_in_bv[0] = base_ch0_vsync; w_in_w[0] = width_ch0;
        w_in_bh[1] = base_ch1_hsync; w_in_bv[1] = base_ch1_vsync; w_in_w[1] = width_ch1;
        w_in_bh[2] = base_ch2_hsync; w_in_bv[2] = base_ch2_vsync; w_in_w[2] = width_ch2;
    end

    // Window hit test in 17 bits so windows near the top of the range never wrap
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            w_xs[n]  = 17'(r_bh[n]) << HBASE_SH;
            w_hit[n] = (r_w[n] != 16'd0)
                    && ({1'b0, r_xcnt} >= w_xs[n])
                    && ({1'b0, r_xcnt} <  w_xs[n] + {1'b0, r_w[n]})
                    && ({1'b0, r_ycnt} >= {1'b0, r_bv[n]})
                    && ({1'b0, r_ycnt} <  {1'b0, r_bv[n]} + {1'b0, WIN_H});
        end
    end

    // Priority select ch2 > ch1 > ch0 and window-relative coordinates
    always_comb begin
        w_sel = 2'd3;
        w_wx  = 16'd0;
        w_wy  = 16'd0;
        if (w_hit[2]) begin
            w_sel = 2'd2; w_wx = r_xcnt - w_xs[2][15:0]; w_wy = r_ycnt - r_bv[2];
        end else if (w_hit[1]) begin
            w_sel = 2'd1; w_wx = r_xcnt - w_xs[1][15:0]; w_wy = r_ycnt - r_bv[1];
        end else if (w_hit[0]) begin
            w_sel = 2'd0; w_wx = r_xcnt - w_xs[0][15:0]; w_wy = r_ycnt - r_bv[0];
        end
    end

    // Timing FSM and saturating pixel/line counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= SYNC_WAIT;
            r_vs_d  <= 1'b0;
            r_xcnt  <= 16'd0;
            r_ycnt  <= 16'd0;
        end else begin
            r_vs_d <= vsync_i;
            if (w_vs_rise) begin
                r_state <= BLANK;
                r_xcnt  <= 16'd0;
                r_ycnt  <= 16'd0;
            end else begin
                case (r_state)
                    BLANK: if (de_i) begin
                        r_state <= LINE;
                        if (r_xcnt != 16'hFFFF) r_xcnt <= r_xcnt + 16'd1;
                    end
                    LINE: if (de_i) begin
                        if (r_xcnt != 16'hFFFF) r_xcnt <= r_xcnt + 16'd1;
                    end else begin
                        r_state <= BLANK;
                        r_xcnt  <= 16'd0;
                        if (r_ycnt != 16'hFFFF) r_ycnt <= r_ycnt + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Shadow config load at frame start; only enabled channels are refreshed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < 3; n++) begin
                r_bh[n] <= 8'd0;
                r_bv[n] <= 16'd0;
                r_w[n]  <= 16'd0;
            end
            img_mode_act <= 8'd0;
        end else if (w_vs_rise) begin
            for (int n = 0; n < 3; n++) begin
                if (chx_load_en[n]) begin
                    r_bh[n] <= w_in_bh[n];
                    r_bv[n] <= w_in_bv[n];
                    r_w[n]  <= w_in_w[n];
                end
            end
            img_mode_act <= img_mode;
        end
    end

    // Registered pixel outputs, forced to idle values when no pixel is accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_de      <= 1'b0;
            win_hit     <= 3'd0;
            win_sel     <= 2'd3;
            win_x       <= 16'd0;
            win_y       <= 16'd0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_vs_rise;
            out_de      <= w_acc;
            win_hit     <= w_acc ? w_hit : 3'd0;
            win_sel     <= w_acc ? w_sel : 2'd3;
            win_x       <= w_acc ? w_wx  : 16'd0;
            win_y       <= w_acc ? w_wy  : 16'd0;
        end
    end

endmodule

// File: tb/tb_vpu_win_gen.sv
// tb_vpu_win_gen: directed table-driven bench for vpu_win_gen.
module tb_vpu_win_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vsync_i = 1'b0;
    logic        de_i = 1'b0;
    logic [7:0]  base_ch0_hsync = '0, base_ch1_hsync = '0, base_ch2_hsync = '0;
    logic [15:0] base_ch0_vsync = '0, base_ch1_vsync = '0, base_ch2_vsync = '0;
    logic [15:0] width_ch0 = '0, width_ch1 = '0, width_ch2 = '0;
    logic [7:0]  chx_load_en = '0;
    logic [7:0]  img_mode = '0;
    logic        out_de;
    logic [2:0]  win_hit;
    logic [1:0]  win_sel;
    logic [15:0] win_x, win_y;
    logic        frame_start;
    logic [7:0]  img_mode_act;

    vpu_win_gen dut (
        .clock(clock), .reset(reset), .vsync_i(vsync_i), .de_i(de_i),
        .base_ch0_hsync(base_ch0_hsync), .base_ch1_hsync(base_ch1_hsync),
        .base_ch2_hsync(base_ch2_hsync),
        .base_ch0_vsync(base_ch0_vsync), .base_ch1_vsync(base_ch1_vsync),
        .base_ch2_vsync(base_ch2_vsync),
        .width_ch0(width_ch0), .width_ch1(width_ch1), .width_ch2(width_ch2),
        .chx_load_en(chx_load_en), .img_mode(img_mode),
        .out_de(out_de), .win_hit(win_hit), .win_sel(win_sel),
        .win_x(win_x), .win_y(win_y), .frame_start(frame_start),
        .img_mode_act(img_mode_act)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          sc;
        int          y;
        int          x;
        logic [2:0]  hit;
        logic [1:0]  sel;
        logic [15:0] wx;
        logic [15:0] wy;
    } vec_t;

    vec_t        vt[$];
    logic [37:0] cap[int];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [37:0] outv();
        return {out_de, win_hit, win_sel, win_x, win_y};
    endfunction

    // Apply inputs, then sample just after the next rising edge
    task automatic tick(input logic vs, input logic de);
        vsync_i = vs;
        de_i    = de;
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(input int ch, input logic [7:0] bh, input logic [15:0] bv, input logic [15:0] w);
        case (ch)
            0: begin base_ch0_hsync = bh; base_ch0_vsync = bv; width_ch0 = w; end
            1: begin base_ch1_hsync = bh; base_ch1_vsync = bv; width_ch1 = w; end
            default: begin base_ch2_hsync = bh; base_ch2_vsync = bv; width_ch2 = w; end
        endcase
    endtask

    // One frame: vsync pulse, then nl lines of len pixels; optional mid-frame changes after line 0
    task automatic run_frame(input int nl, input int len, input int chg_w1, input int chg_mode);
        cap.delete();
        tick(1'b1, 1'b0); tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < len; x++) begin
                tick(1'b0, 1'b1);
                cap[y * 65536 + x] = outv();
            end
            for (int b = 0; b < 4; b++) tick(1'b0, 1'b0);
            if (y == 0 && chg_w1 >= 0)   width_ch1 = 16'(chg_w1);
            if (y == 0 && chg_mode >= 0) img_mode  = 8'(chg_mode);
        end
    endtask

    task automatic check_sc(input int sc);
        foreach (vt[i]) begin
            if (vt[i].sc == sc) begin
                int          key;
                logic [37:0] a;
                key = vt[i].y * 65536 + vt[i].x;
                a   = cap.exists(key) ? cap[key] : '1;
                chk($sformatf("sc%0d_y%0d_x%0d", sc, vt[i].y, vt[i].x), 64'(a),
                    64'({1'b1, vt[i].hit, vt[i].sel, vt[i].wx, vt[i].wy}));
            end
        end
    endtask

    initial begin
        // sc0: ch0 xs=16, base_v=4, width 32 on 1920-pixel lines
        vt.push_back('{0, 4, 16, 3'b001, 2'd0, 16'd0,  16'd0});
        vt.push_back('{0, 4, 47, 3'b001, 2'd0, 16'd31, 16'd0});
        vt.push_back('{0, 4, 15, 3'b000, 2'd3, 16'd0,  16'd0});
        vt.push_back('{0, 4, 48, 3'b000, 2'd3, 16'd0,  16'd0});
        vt.push_back('{0, 3, 20, 3'b000, 2'd3, 16'd0,  16'd0});
        vt.push_back('{0, 5, 20, 3'b001, 2'd0, 16'd4,  16'd1});
        // sc1: ch0 x0..63 y0.., ch2 x32..47 y2..
        vt.push_back('{1, 2, 40, 3'b101, 2'd2, 16'd8,  16'd0});
        vt.push_back('{1, 1, 40, 3'b001, 2'd0, 16'd40, 16'd1});
        vt.push_back('{1, 3, 47, 3'b101, 2'd2, 16'd15, 16'd1});
        vt.push_back('{1, 2, 48, 3'b001, 2'd0, 16'd48, 16'd2});
        vt.push_back('{1, 2, 31, 3'b001, 2'd0, 16'd31, 16'd2});
        // sc2..5: ch1 xs=8 width 8, then 4, then load disabled
        vt.push_back('{2, 1, 11, 3'b010, 2'd1, 16'd3,  16'd1});
        vt.push_back('{2, 1, 12, 3'b010, 2'd1, 16'd4,  16'd1});
        vt.push_back('{2, 0, 7,  3'b000, 2'd3, 16'd0,  16'd0});
        vt.push_back('{3, 1, 12, 3'b000, 2'd3, 16'd0,  16'd0});
        vt.push_back('{3, 1, 11, 3'b010, 2'd1, 16'd3,  16'd1});
        vt.push_back('{4, 1, 20, 3'b000, 2'd3, 16'd0,  16'd0});
        vt.push_back('{4, 1, 8,  3'b010, 2'd1, 16'd0,  16'd1});
        vt.push_back('{5, 1, 20, 3'b000, 2'd3, 16'd0,  16'd0});
        vt.push_back('{5, 1, 11, 3'b010, 2'd1, 16'd3,  16'd1});
        // sc6/7: xs=2040, width 0xFFFF, base_v 0xFFF0 then 0
        vt.push_back('{6, 0, 2045, 3'b000, 2'd3, 16'd0, 16'd0});
        vt.push_back('{6, 1, 2039, 3'b000, 2'd3, 16'd0, 16'd0});
        vt.push_back('{6, 0, 0,    3'b000, 2'd3, 16'd0, 16'd0});
        vt.push_back('{7, 0, 2040, 3'b001, 2'd0, 16'd0, 16'd0});
        vt.push_back('{7, 1, 2039, 3'b000, 2'd3, 16'd0, 16'd0});
        vt.push_back('{7, 1, 2049, 3'b001, 2'd0, 16'd9, 16'd1});

        // Reset values, then de activity before any vsync must be ignored
        tick(1'b0, 1'b0); tick(1'b0, 1'b0);
        chk("reset_vals", 64'({outv(), frame_start, img_mode_act}), 64'({1'b0, 3'd0, 2'd3, 32'd0, 1'b0, 8'd0}));
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'(i % 2));
            chk($sformatf("nosync_%0d", i), 64'({out_de, win_sel}), 64'({1'b0, 2'd3}));
        end
        img_mode = 8'h11;
        tick(1'b1, 1'b0);
        chk("frame_start_pulse", 64'(frame_start), 64'd1);
        tick(1'b1, 1'b0);
        chk("frame_start_clear", 64'(frame_start), 64'd0);
        chk("img_mode_first", 64'(img_mode_act), 64'h11);
        tick(1'b0, 1'b0);

        // sc0
        cfg(0, 8'd2, 16'd4, 16'd32); chx_load_en = 8'h01; img_mode = 8'h22;
        run_frame(6, 1920, -1, -1);
        check_sc(0);
        chk("img_mode_sc0", 64'(img_mode_act), 64'h22);

        // sc1: overlap, upper load_en bits must be ignored
        cfg(0, 8'd0, 16'd0, 16'd64); cfg(2, 8'd4, 16'd2, 16'd16); chx_load_en = 8'hF5;
        run_frame(4, 64, -1, -1);
        check_sc(1);

        // sc2..5: mid-frame width change with and without load enable
        cfg(0, 8'd0, 16'd0, 16'd0); cfg(2, 8'd0, 16'd0, 16'd0); cfg(1, 8'd1, 16'd0, 16'd8);
        chx_load_en = 8'h07;
        run_frame(2, 32, 4, -1);
        check_sc(2);
        chx_load_en = 8'h02;
        run_frame(2, 32, -1, -1);
        check_sc(3);
        chx_load_en = 8'h00; img_mode = 8'hC3;
        run_frame(2, 32, 32, 8'h5A);
        check_sc(4);
        chk("img_mode_midframe", 64'(img_mode_act), 64'hC3);
        run_frame(2, 32, -1, -1);
        check_sc(5);
        chk("img_mode_next", 64'(img_mode_act), 64'h5A);

        // sc6/7: far-right window, no wrap of upper bounds
        cfg(0, 8'd255, 16'hFFF0, 16'hFFFF); cfg(1, 8'd0, 16'd0, 16'd0); chx_load_en = 8'h07;
        run_frame(2, 2050, -1, -1);
        check_sc(6);
        base_ch0_vsync = 16'd0;
        run_frame(2, 2050, -1, -1);
        check_sc(7);

        // vsync rise coincident with de: that pixel is dropped, next is (0,0)
        cfg(0, 8'd0, 16'd0, 16'd16);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        chk("vsrise_de_drop", 64'({out_de, frame_start}), 64'({1'b0, 1'b1}));
        tick(1'b1, 1'b1);
        chk("first_px", 64'(outv()), 64'({1'b1, 3'b001, 2'd0, 16'd0, 16'd0}));
        tick(1'b1, 1'b1);
        chk("second_px", 64'(outv()), 64'({1'b1, 3'b001, 2'd0, 16'd1, 16'd0}));

        // Reset mid-line: immediate return to reset values, then re-wait for vsync
        #2 reset = 1'b1;
        #1;
        chk("async_reset", 64'({outv(), frame_start, img_mode_act}), 64'({1'b0, 3'd0, 2'd3, 32'd0, 1'b0, 8'd0}));
        @(posedge clock); #1;
        tick(1'b0, 1'b1);
        reset = 1'b0;
        tick(1'b0, 1'b1); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        chk("post_reset_no_vsync", 64'({out_de, win_sel}), 64'({1'b0, 2'd3}));
        chx_load_en = 8'h00;
        tick(1'b1, 1'b0); tick(1'b0, 1'b0); tick(1'b0, 1'b1);
        chk("shadow_cleared", 64'(outv()), 64'({1'b1, 3'b000, 2'd3, 16'd0, 16'd0}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
